mmio_uart_tx_queue: RTL and testbench
=====================================

# mmio_uart_tx_queue

CPU-side transmit queue between the CPU data-memory port and the PDU UART channel. CPU stores to a memory-mapped TX data address are pushed, one byte each, into a small FIFO. The FIFO head is presented to the PDU as a valid/data stream and popped on the PDU's accept strobe. The block also returns a status word on CPU loads, so software can poll for space, and it raises a sticky overflow flag when a byte is dropped.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- BASE_ADDR, 32'hFFFF0000, MMIO base. TX data register at BASE_ADDR+0, status register at BASE_ADDR+4.

Ports:
- clk  in  1  CPU clock (25 MHz domain); all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_dmem_addr  in  32  CPU data address.
- cpu_dmem_we  in  1  CPU store strobe, already qualified as MMIO.
- cpu_dmem_wdata  in  32  CPU store data.
- cpu_dmem_rdata  out  32  combinational read data for the two registers.
- cpu_uart_data_valid  out  1  FIFO not empty.
- cpu_uart_data  out  8  FIFO head byte.
- pdu_uart_data_accept  in  1  PDU consumes the head byte this cycle.
- fifo_count  out  CW  current occupancy, where CW = $clog2(DEPTH)+1.

## Operation
- Storage: DEPTH x 8 register array, rd_ptr and wr_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, and count of CW bits.
- push_req = cpu_dmem_we & (cpu_dmem_addr == BASE_ADDR). The pushed byte is cpu_dmem_wdata[7:0]; bits 31:8 are ignored.
- pop = cpu_uart_data_valid & pdu_uart_data_accept. An accept while the FIFO is empty is ignored.
- push = push_req & ((count < DEPTH) | pop). A push while full is accepted only if a pop happens in the same cycle.
- Drop: push_req & ~push sets the sticky overflow bit. No state other than overflow changes.
- Clearing overflow: a store to BASE_ADDR+4 with wdata[2]=1 clears it. If a drop occurs in the same cycle, the set wins.
- Count update: +1 on push only, -1 on pop only, unchanged on both.
- Write path: mem[wr_ptr] <= byte on push.
- Read path: cpu_uart_data = mem[rd_ptr] (combinational). cpu_uart_data_valid = (count != 0).
- Status word: {16'b0, count zero-extended to 8 bits, 5'b0, overflow, empty, full}, where full = (count == DEPTH) and empty = (count == 0).
- cpu_dmem_rdata returns the status word when addr == BASE_ADDR+4, and 0 for every other address, including the TX data address.
- Other stores in the MMIO window are ignored.

## Timing
- Reset (rst low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, overflow=0. Array contents are don't-care.
- Outputs while in reset: cpu_uart_data_valid=0, fifo_count=0, status=32'h00000002.
- Release: reset is released synchronously to clk. The first store can be accepted on the first edge after release.
- Store-to-valid latency: one cycle. A store sampled at edge N gives valid=1 and data equal to the stored byte after edge N.
- Pop: the head advances at the edge where valid & accept are both high. The next byte (or valid=0) is visible after that edge.
- Back-to-back: one pop per cycle when accept is held high.
- Status latency: status reflects register state after the last edge, combinationally. A store at edge N is visible to a load in cycle N+1.
- Simultaneous events:
  - push+pop when empty: the pop is not possible (valid=0), so the push proceeds.
  - push+pop when full: both proceed, count stays DEPTH, no overflow.
- Wrap-around: the pointers roll from DEPTH-1 to 0 without a bubble.
- Reset mid-transfer: queued bytes are discarded and valid drops immediately, asynchronously.

## Test plan
- Reset: hold rst=0 with accept=1 -> valid=0, fifo_count=0, load at BASE+4 returns 32'h00000002. Release, then store 32'h12345641 to BASE+0 -> next cycle valid=1, data=8'h41, status=32'h00000100.
- Ordering and wrap: accept=0; store bytes 0x30..0x37 -> status=32'h00000801 (full). Pop all with accept held high -> 0x30..0x37 appear on consecutive cycles. Repeat 3 times to exercise pointer wrap.
- Overflow: fill with 8 bytes, store 0x99 with accept=0 -> count stays 8, status bit2=1, 0x99 never emitted. Store 32'h4 to BASE+4 -> bit2 clears. Set and clear in the same cycle -> bit2=1.
- Full with simultaneous push/pop: full FIFO, store 0xAA with accept=1 in the same cycle -> count stays 8, no overflow, 0xAA emitted last.
- Spurious accept: empty FIFO, accept=1 for 5 cycles -> count stays 0, pointers unchanged. A subsequent single store is emitted exactly once.
- Reset mid-stream: 5 bytes queued, pulse rst low for less than one cycle between edges -> valid=0 immediately, count=0, overflow=0. After reset, loads at BASE+0 and BASE+8 return 0.

Source files
------------

// File: rtl/mmio_uart_tx_queue.sv
// CPU-side UART transmit queue: MMIO byte stores feed a small FIFO drained by the PDU.
// A status register gives software occupancy, full/empty and a sticky overflow flag.
module mmio_uart_tx_queue #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  localparam int         AW        = $clog2(DEPTH),
  localparam int         CW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   cpu_dmem_addr,
  input  logic          cpu_dmem_we,
  input  logic [31:0]   cpu_dmem_wdata,
  output logic [31:0]   cpu_dmem_rdata,
  output logic          cpu_uart_data_valid,
  output logic [7:0]    cpu_uart_data,
  input  logic          pdu_uart_data_accept,
  output logic [CW-1:0] fifo_count
);

  localparam logic [31:0]   TXD_ADDR  = BASE_ADDR;
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_clr;
  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push_req = cpu_dmem_we && (cpu_dmem_addr == TXD_ADDR);
  assign w_pop      = !w_empty && pdu_uart_data_accept;
  // A full queue still takes a byte when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;
  assign w_clr      = cpu_dmem_we && (cpu_dmem_addr == STAT_ADDR) && cpu_dmem_wdata[2];

  // Only the low byte is queued; the rest of the store data is don't-care.
  assign w_unused   = ^cpu_dmem_wdata[31:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Set has priority so a drop is never lost to a concurrent clear.
      if (w_drop)     r_ovf <= 1'b1;
      else if (w_clr) r_ovf <= 1'b0;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cpu_dmem_wdata[7:0];
  end

  assign w_status = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_empty, w_full};

  always_comb begin
    cpu_dmem_rdata = 32'h0;
    if (cpu_dmem_addr == STAT_ADDR) cpu_dmem_rdata = w_status;
  end

  assign cpu_uart_data_valid = !w_empty;
  assign cpu_uart_data       = r_mem[r_rd_ptr];
  assign fifo_count          = r_count;

endmodule

// File: tb/tb_mmio_uart_tx_queue.sv
// Directed bench for mmio_uart_tx_queue: reset, ordering/wrap, overflow, full push+pop,
// spurious accepts and asynchronous reset mid-stream.
module tb_mmio_uart_tx_queue;

  localparam logic [31:0] BASE = 32'hFFFF0000;
  localparam logic [31:0] STAT = BASE + 32'd4;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid;
  logic [7:0]  data;
  logic        accept;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  mmio_uart_tx_queue #(.DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cpu_dmem_addr        (addr),
    .cpu_dmem_we          (we),
    .cpu_dmem_wdata       (wdata),
    .cpu_dmem_rdata       (rdata),
    .cpu_uart_data_valid  (valid),
    .cpu_uart_data        (data),
    .pdu_uart_data_accept (accept),
    .fifo_count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One store, presented at a negedge and sampled by the next posedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0; addr = STAT; wdata = 32'h0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; accept = 1'b1; we = 1'b0; addr = STAT; wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (rdata !== 32'h00000002) begin errors++; $display("FAIL reset_status: got %h want 00000002", rdata); end
    @(negedge clk);
    rst = 1'b1; accept = 1'b0;
    store(BASE, 32'h12345641);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", valid); end
    checks++; if (data !== 8'h41) begin errors++; $display("FAIL first_data: got %h want 41", data); end
    checks++; if (rdata !== 32'h00000100) begin errors++; $display("FAIL first_status: got %h want 00000100", rdata); end
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_drain: got %b want 0", valid); end
  endtask

  task automatic test_order_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) store(BASE, 32'h30 + i);
      checks++; if (rdata !== 32'h00000801) begin errors++; $display("FAIL wrap_full r%0d: got %h want 00000801", r, rdata); end
      accept = 1'b1;
      for (int i = 0; i < 8; i++) begin
        #1;
        checks++;
        if (valid !== 1'b1 || data !== 8'(8'h30 + i)) begin
          errors++; $display("FAIL wrap_pop r%0d i%0d: got v=%b d=%h want v=1 d=%h", r, i, valid, data, 8'(8'h30 + i));
        end
        @(negedge clk);
      end
      accept = 1'b0; #1;
      checks++; if (valid !== 1'b0 || rdata !== 32'h00000002) begin errors++; $display("FAIL wrap_empty r%0d: got v=%b st=%h want v=0 st=00000002", r, valid, rdata); end
    end
  endtask

  task automatic test_overflow();
    accept = 1'b0;
    for (int i = 0; i < 8; i++) store(BASE, 32'h50 + i);
    store(BASE, 32'h99);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", count); end
    checks++; if (rdata !== 32'h00000805) begin errors++; $display("FAIL ovf_set: got %h want 00000805", rdata); end
    store(STAT, 32'h4);
    checks++; if (rdata !== 32'h00000801) begin errors++; $display("FAIL ovf_clear: got %h want 00000801", rdata); end
    store(BASE, 32'h99);
    store(STAT, 32'hFFFFFFFB);
    checks++; if (rdata !== 32'h00000805) begin errors++; $display("FAIL ovf_noclr_bit2_0: got %h want 00000805", rdata); end
    accept = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (valid !== 1'b1 || data !== 8'(8'h50 + i)) begin
        errors++; $display("FAIL ovf_drain i%0d: got v=%b d=%h want v=1 d=%h", i, valid, data, 8'(8'h50 + i));
      end
      @(negedge clk);
    end
    accept = 1'b0; #1;
    checks++; if (valid !== 1'b0 || rdata !== 32'h00000006) begin errors++; $display("FAIL ovf_dropped_absent: got v=%b st=%h want v=0 st=00000006", valid, rdata); end
    store(STAT, 32'h4);
    checks++; if (rdata !== 32'h00000002) begin errors++; $display("FAIL ovf_final_clear: got %h want 00000002", rdata); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp [8];
    accept = 1'b0;
    for (int i = 0; i < 8; i++) store(BASE, 32'h60 + i);
    for (int i = 0; i < 7; i++) exp[i] = 8'(8'h61 + i);
    exp[7] = 8'hAA;
    accept = 1'b1;
    store(BASE, 32'h000000AA);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL pp_count: got %0d want 8", count); end
    checks++; if (rdata !== 32'h00000801) begin errors++; $display("FAIL pp_status: got %h want 00000801", rdata); end
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (valid !== 1'b1 || data !== exp[i]) begin
        errors++; $display("FAIL pp_order i%0d: got v=%b d=%h want v=1 d=%h", i, valid, data, exp[i]);
      end
      @(negedge clk);
    end
    accept = 1'b0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", valid); end
  endtask

  task automatic test_spurious_accept();
    accept = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (count !== 4'd0 || valid !== 1'b0) begin errors++; $display("FAIL spur_idle c%0d: got cnt=%0d v=%b want 0 0", i, count, valid); end
    end
    accept = 1'b0;
    store(BASE, 32'h77);
    checks++; if (valid !== 1'b1 || data !== 8'h77 || count !== 4'd1) begin errors++; $display("FAIL spur_store: got v=%b d=%h cnt=%0d want 1 77 1", valid, data, count); end
    accept = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL spur_once: got v=%b cnt=%0d want 0 0", valid, count); end
    accept = 1'b0;
  endtask

  task automatic test_reset_mid();
    accept = 1'b0;
    for (int i = 0; i < 8; i++) store(BASE, 32'h70 + i);
    store(BASE, 32'h99);
    accept = 1'b1;
    repeat (3) @(negedge clk);
    accept = 1'b0; #1;
    checks++; if (rdata !== 32'h00000504 || data !== 8'h73) begin errors++; $display("FAIL mid_pre: got st=%h d=%h want 00000504 73", rdata, data); end
    rst = 1'b0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", count); end
    checks++; if (rdata !== 32'h00000002) begin errors++; $display("FAIL mid_status: got %h want 00000002", rdata); end
    rst = 1'b1;
    @(negedge clk);
    store(BASE, 32'hCAFE0011);
    checks++; if (valid !== 1'b1 || data !== 8'h11) begin errors++; $display("FAIL mid_restart: got v=%b d=%h want 1 11", valid, data); end
    addr = BASE; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_txdata: got %h want 00000000", rdata); end
    addr = BASE + 32'd8; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rd_other: got %h want 00000000", rdata); end
    addr = STAT;
  endtask

  initial begin
    test_reset();
    test_order_wrap();
    test_overflow();
    test_full_pushpop();
    test_spurious_accept();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
